// File: rtl/crypto_core_arbiter_if.sv
// Signal bundle between crypto_core_arbiter, its byte sources/sink and the cipher datapath.
// master = arbiter side, slave = environment (requesters, response sink, cipher core).
interface crypto_core_arbiter_if;
   logic        key_load;
   logic [7:0]  key_in;
   logic        key_ack;
   logic        req0_valid;
   logic [7:0]  req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [7:0]  req1_data;
   logic        req1_ready;
   logic        core_sel;
   logic [7:0]  core_din;
   logic [7:0]  core_key;
   logic [7:0]  core_dout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_id;
   logic [15:0] enc_count;
   logic [15:0] dec_count;

   modport master (
      input  key_load, key_in, req0_valid, req0_data, req1_valid, req1_data,
             core_dout, rsp_ready,
      output key_ack, req0_ready, req1_ready, core_sel, core_din, core_key,
             rsp_valid, rsp_data, rsp_id, enc_count, dec_count
   );

   modport slave (
      output key_load, key_in, req0_valid, req0_data, req1_valid, req1_data,
             core_dout, rsp_ready,
      input  key_ack, req0_ready, req1_ready, core_sel, core_din, core_key,
             rsp_valid, rsp_data, rsp_id, enc_count, dec_count
   );
endinterface

// File: rtl/crypto_core_arbiter.sv
// Round-robin sharer of the 8-bit cipher core between an encrypt (req0) and a decrypt (req1) channel.
// Define CRYPTO_ARB_STATS_EN to build the saturating enc/dec response counters; otherwise they read 0.
module crypto_core_arbiter #(
   parameter int unsigned CORE_LAT = 1
) (
   input logic                   clk,
   input logic                   rst,
   crypto_core_arbiter_if.master bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [3:0] LAT_INIT = 4'(CORE_LAT);

   logic [1:0] state;
   logic [7:0] key_reg;
   logic [7:0] din_reg;
   logic       sel_reg;
   logic       last_grant;
   logic [3:0] wait_cnt;
   logic       rsp_valid_reg;
   logic [7:0] rsp_data_reg;
   logic       rsp_id_reg;
   logic       idle;
   logic       grant0;
   logic       grant1;

   assign idle = (state == IDLE);

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (idle && !bus.key_load) begin
         if (bus.req0_valid && bus.req1_valid) begin
            // tie goes to the requester that was not served last
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   assign bus.key_ack    = idle && bus.key_load;
   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.core_sel   = sel_reg;
   assign bus.core_din   = din_reg;
   assign bus.core_key   = key_reg;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_data   = rsp_data_reg;
   assign bus.rsp_id     = rsp_id_reg;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         key_reg       <= 8'h00;
         din_reg       <= 8'h00;
         sel_reg       <= 1'b1;
         last_grant    <= 1'b1;
         wait_cnt      <= 4'd0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= 8'h00;
         rsp_id_reg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.key_load) begin
                  key_reg <= bus.key_in;
               end else if (grant0 || grant1) begin
                  din_reg    <= grant0 ? bus.req0_data : bus.req1_data;
                  sel_reg    <= grant0;
                  last_grant <= grant1;
                  wait_cnt   <= LAT_INIT;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               // core output is settled in the last latency cycle; capture it so rsp_data is registered
               if (wait_cnt == 4'd1) begin
                  rsp_data_reg  <= bus.core_dout;
                  rsp_id_reg    <= last_grant;
                  rsp_valid_reg <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CRYPTO_ARB_STATS_EN
   logic [15:0] enc_cnt;
   logic [15:0] dec_cnt;
   logic        rsp_done;

   assign rsp_done = (state == RESP) && bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         enc_cnt <= 16'h0000;
         dec_cnt <= 16'h0000;
      end else if (rsp_done) begin
         if (!rsp_id_reg) begin
            if (enc_cnt != 16'hFFFF) enc_cnt <= enc_cnt + 16'd1;
         end else begin
            if (dec_cnt != 16'hFFFF) dec_cnt <= dec_cnt + 16'd1;
         end
      end
   end

   assign bus.enc_count = enc_cnt;
   assign bus.dec_count = dec_cnt;
`else
   assign bus.enc_count = 16'h0000;
   assign bus.dec_count = 16'h0000;
`endif
endmodule

// File: tb/tb_crypto_core_arbiter.sv
// Scoreboard bench: lane 0 runs CORE_LAT=1 with a combinational core, lane 1 CORE_LAT=3 with a registered core.
// An issue process predicts grants and pushes expected responses; a monitor pops and compares them.
module tb_crypto_core_arbiter;
   typedef struct {
      logic       id;
      logic [7:0] din;
      logic [7:0] data;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic       key_load_s [2];
   logic [7:0] key_in_s   [2];
   logic       v0_s       [2];
   logic [7:0] d0_s       [2];
   logic       v1_s       [2];
   logic [7:0] d1_s       [2];
   logic       rdy_s      [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in team cipher: encrypt rotates left then whitens with key and 0xC3; decrypt undoes it.
   // Reference pair under key 0x18: 0x84 <-> 0xD2.
   function automatic logic [7:0] core_fn(input logic sel, input logic [7:0] x, input logic [7:0] k);
      logic [7:0] t;
      if (sel) return {x[6:0], x[7]} ^ k ^ 8'hC3;
      t = x ^ k ^ 8'hC3;
      return {t[0], t[7:1]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int LAT = (g == 0) ? 1 : 3;

      crypto_core_arbiter_if bus ();

      assign bus.key_load   = key_load_s[g];
      assign bus.key_in     = key_in_s[g];
      assign bus.req0_valid = v0_s[g];
      assign bus.req0_data  = d0_s[g];
      assign bus.req1_valid = v1_s[g];
      assign bus.req1_data  = d1_s[g];
      assign bus.rsp_ready  = rdy_s[g];

      if (g == 0) begin : g_comb_core
         assign bus.core_dout = core_fn(bus.core_sel, bus.core_din, bus.core_key);
      end else begin : g_reg_core
         logic [7:0] core_q = 8'h00;
         always @(posedge clk) core_q <= core_fn(bus.core_sel, bus.core_din, bus.core_key);
         assign bus.core_dout = core_q;
      end

      crypto_core_arbiter #(.CORE_LAT(LAT)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      exp_t       sb[$];
      exp_t       e;
      logic       last_m = 1'b1;
      logic [7:0] key_m = 8'h00;
      logic       w0;
      logic       w1;
      logic [7:0] din_m;
      int         enc_m = 0;
      int         dec_m = 0;
      int         enc_x;
      int         dec_x;
      logic       prev_valid = 1'b0;
      int         n_rsp = 0;

      // Issue side: arbitration rules from the request inputs, push of the expected result on accept.
      always @(negedge clk) begin
         w0 = 1'b0;
         w1 = 1'b0;
         if (sb.size() == 0) begin
            if (!key_load_s[g]) begin
               if (v0_s[g] && v1_s[g]) begin
                  w0 = last_m;
                  w1 = !last_m;
               end else begin
                  w0 = v0_s[g];
                  w1 = v1_s[g];
               end
            end
            check($sformatf("L%0d idle {key_ack,rdy1,rdy0}", g),
                  32'({bus.key_ack, bus.req1_ready, bus.req0_ready}), 32'({key_load_s[g], w1, w0}));
            check($sformatf("L%0d idle rsp_valid", g), 32'(bus.rsp_valid), 32'd0);
         end else begin
            check($sformatf("L%0d busy {key_ack,rdy1,rdy0}", g),
                  32'({bus.key_ack, bus.req1_ready, bus.req0_ready}), 32'd0);
         end
         check($sformatf("L%0d core_key", g), 32'(bus.core_key), 32'(key_m));

         if (rst) begin
            sb.delete();
            last_m = 1'b1;
            key_m  = 8'h00;
         end else if (sb.size() == 0) begin
            if (key_load_s[g]) begin
               key_m = key_in_s[g];
            end else if (w0 || w1) begin
               din_m = w1 ? d1_s[g] : d0_s[g];
               sb.push_back('{id: w1, din: din_m, data: core_fn(w0, din_m, key_m), acc: cyc});
               last_m = w1;
            end
         end
      end

      // Monitor side: response content, latency, hold under backpressure, completion counters.
      always @(negedge clk) begin
         #2;
`ifdef CRYPTO_ARB_STATS_EN
         enc_x = enc_m;
         dec_x = dec_m;
`else
         enc_x = 0;
         dec_x = 0;
`endif
         check($sformatf("L%0d enc_count", g), 32'(bus.enc_count), 32'(enc_x));
         check($sformatf("L%0d dec_count", g), 32'(bus.dec_count), 32'(dec_x));
         if (sb.size() != 0 && sb[0].acc != cyc) begin
            check($sformatf("L%0d core_sel", g), 32'(bus.core_sel), 32'(!sb[0].id));
            check($sformatf("L%0d core_din", g), 32'(bus.core_din), 32'(sb[0].din));
            if (bus.rsp_valid) begin
               if (!prev_valid)
                  check($sformatf("L%0d latency", g), 32'(cyc - sb[0].acc), 32'(LAT + 1));
               check($sformatf("L%0d rsp_data", g), 32'(bus.rsp_data), 32'(sb[0].data));
               check($sformatf("L%0d rsp_id", g), 32'(bus.rsp_id), 32'(sb[0].id));
               if (rdy_s[g] && !rst) begin
                  e = sb.pop_front();
                  n_rsp++;
                  if (e.id) dec_m = (dec_m < 65535) ? dec_m + 1 : dec_m;
                  else      enc_m = (enc_m < 65535) ? enc_m + 1 : enc_m;
               end
            end else if (cyc - sb[0].acc >= LAT + 1) begin
               check($sformatf("L%0d rsp_valid by deadline", g), 32'(bus.rsp_valid), 32'd1);
            end
         end
         prev_valid = rst ? 1'b0 : bus.rsp_valid;
         if (rst) begin
            enc_m = 0;
            dec_m = 0;
         end
      end
   end

   task automatic load_key(input logic [7:0] k);
      bit got = 0;
      key_load_s[0] = 1'b1;
      key_in_s[0]   = k;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (lane[0].bus.key_ack) got = 1;
      end
      check("L0 key_ack arrives", 32'(got), 32'd1);
      @(posedge clk); #1;
      key_load_s[0] = 1'b0;
   endtask

   task automatic send(input logic id, input logic [7:0] d, output int acc);
      bit got = 0;
      acc = -1;
      if (id) begin v1_s[0] = 1'b1; d1_s[0] = d; end
      else    begin v0_s[0] = 1'b1; d0_s[0] = d; end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (id ? lane[0].bus.req1_ready : lane[0].bus.req0_ready) begin
            got = 1;
            acc = cyc;
         end
      end
      check($sformatf("L0 grant of req%0d", id), 32'(got), 32'd1);
      @(posedge clk); #1;
      if (id) v1_s[0] = 1'b0;
      else    v0_s[0] = 1'b0;
   endtask

   task automatic await_rsp(output logic [7:0] data, output logic id, output int at);
      bit got = 0;
      at = -1; data = 8'h00; id = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (lane[0].bus.rsp_valid) begin
            got = 1; at = cyc; data = lane[0].bus.rsp_data; id = lane[0].bus.rsp_id;
         end
      end
      check("L0 response arrives", 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int         acc;
      int         rc;
      logic [7:0] rd;
      logic       rid;
      logic [7:0] cap;
      logic [7:0] bp_d;
      logic [7:0] a0 [4];
      logic [7:0] a1 [4];
      int         i0;
      int         i1;
      bit         got;
      logic       gid;

      for (int i = 0; i < 2; i++) begin
         key_load_s[i] = 1'b0; key_in_s[i] = 8'h00;
         v0_s[i] = 1'b0; d0_s[i] = 8'h00; v1_s[i] = 1'b0; d1_s[i] = 8'h00;
         rdy_s[i] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("reset rsp_valid", 32'(lane[0].bus.rsp_valid), 32'd0);
      check("reset rsp_data", 32'(lane[0].bus.rsp_data), 32'h00);
      check("reset rsp_id", 32'(lane[0].bus.rsp_id), 32'd0);
      check("reset core_sel", 32'(lane[0].bus.core_sel), 32'd1);
      check("reset core_din", 32'(lane[0].bus.core_din), 32'h00);
      check("reset core_key", 32'(lane[0].bus.core_key), 32'h00);

      // key load then encrypt of the reference byte
      load_key(8'h18);
      send(1'b0, 8'h84, acc);
      @(negedge clk);
      check("enc core_sel", 32'(lane[0].bus.core_sel), 32'd1);
      check("enc core_key", 32'(lane[0].bus.core_key), 32'h18);
      await_rsp(rd, rid, rc);
      check("enc rsp_data", 32'(rd), 32'hD2);
      check("enc rsp_id", 32'(rid), 32'd0);
      check("enc accept-to-valid", 32'(rc - acc), 32'd2);

      // decrypt of the reference ciphertext
      send(1'b1, 8'hD2, acc);
      @(negedge clk);
      check("dec core_sel", 32'(lane[0].bus.core_sel), 32'd0);
      await_rsp(rd, rid, rc);
      check("dec rsp_data", 32'(rd), 32'h84);
      check("dec rsp_id", 32'(rid), 32'd1);
      @(negedge clk);
`ifdef CRYPTO_ARB_STATS_EN
      check("dec_count after decrypt", 32'(lane[0].bus.dec_count), 32'd1);
`else
      check("dec_count tied off", 32'(lane[0].bus.dec_count), 32'd0);
`endif
      @(posedge clk); #1;

      // arbitration: both channels valid with four bytes each, starting from reset
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin a0[k] = 8'($urandom); a1[k] = 8'($urandom); end
      i0 = 0; i1 = 0;
      v0_s[0] = 1'b1; d0_s[0] = a0[0];
      v1_s[0] = 1'b1; d1_s[0] = a1[0];
      for (int k = 0; k < 8; k++) begin
         got = 0; gid = 1'b0;
         for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (lane[0].bus.req0_ready || lane[0].bus.req1_ready) begin
               got = 1; gid = lane[0].bus.req1_ready;
            end
         end
         check("arb grant seen", 32'(got), 32'd1);
         check($sformatf("arb grant %0d id", k), 32'(gid), 32'(k % 2));
         @(posedge clk); #1;
         if (got && !gid) begin
            i0++;
            if (i0 == 4) v0_s[0] = 1'b0; else d0_s[0] = a0[i0];
         end else if (got) begin
            i1++;
            if (i1 == 4) v1_s[0] = 1'b0; else d1_s[0] = a1[i1];
         end
      end
      v0_s[0] = 1'b0; v1_s[0] = 1'b0;
      repeat (6) begin @(posedge clk); #1; end

      // backpressure with a key load and a decrypt request parked during RESP
      rdy_s[0] = 1'b0;
      bp_d = 8'($urandom);
      send(1'b0, 8'($urandom), acc);
      v1_s[0] = 1'b1; d1_s[0] = bp_d;
      got = 0; cap = 8'h00;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (lane[0].bus.rsp_valid) begin got = 1; cap = lane[0].bus.rsp_data; end
      end
      check("bp response arrives", 32'(got), 32'd1);
      @(posedge clk); #1;
      key_load_s[0] = 1'b1; key_in_s[0] = 8'h55;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp rsp_valid held", 32'(lane[0].bus.rsp_valid), 32'd1);
         check("bp rsp_data stable", 32'(lane[0].bus.rsp_data), 32'(cap));
         check("bp {key_ack,rdy1,rdy0}",
               32'({lane[0].bus.key_ack, lane[0].bus.req1_ready, lane[0].bus.req0_ready}), 32'd0);
         @(posedge clk); #1;
      end
      rdy_s[0] = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp key_ack in first idle", 32'(lane[0].bus.key_ack), 32'd1);
      check("bp no grant during key load", 32'(lane[0].bus.req1_ready), 32'd0);
      @(posedge clk); #1;
      key_load_s[0] = 1'b0;
      @(negedge clk);
      check("bp req1 granted after key", 32'(lane[0].bus.req1_ready), 32'd1);
      acc = cyc;
      @(posedge clk); #1;
      v1_s[0] = 1'b0;
      @(negedge clk);
      check("bp new core_key", 32'(lane[0].bus.core_key), 32'h55);
      check("bp core_sel", 32'(lane[0].bus.core_sel), 32'd0);
      await_rsp(rd, rid, rc);
      check("bp rsp_data with new key", 32'(rd), 32'(core_fn(1'b0, bp_d, 8'h55)));
      check("bp rsp_id", 32'(rid), 32'd1);
      check("bp accept-to-valid", 32'(rc - acc), 32'd2);

      // randomized traffic on both lanes, including the CORE_LAT=3 lane
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < 2; i++) begin
            key_load_s[i] = ($urandom_range(0, 9) == 0);
            key_in_s[i]   = 8'($urandom);
            v0_s[i]       = 1'($urandom_range(0, 1));
            d0_s[i]       = 8'($urandom);
            v1_s[i]       = 1'($urandom_range(0, 1));
            d1_s[i]       = 8'($urandom);
            rdy_s[i]      = ($urandom_range(0, 3) != 0);
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 2; i++) begin
         key_load_s[i] = 1'b0; v0_s[i] = 1'b0; v1_s[i] = 1'b0; rdy_s[i] = 1'b1;
      end
      repeat (12) begin @(posedge clk); #1; end
      check("L1 responses observed", 32'(lane[1].n_rsp > 20), 32'd1);
      check("L1 scoreboard drained", 32'(lane[1].sb.size()), 32'd0);

      // reset while lane 0 is waiting on the core
      send(1'b0, 8'h3C, acc);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst-mid rsp_valid", 32'(lane[0].bus.rsp_valid), 32'd0);
      check("rst-mid core_key", 32'(lane[0].bus.core_key), 32'h00);
      check("rst-mid core_din", 32'(lane[0].bus.core_din), 32'h00);
      check("rst-mid core_sel", 32'(lane[0].bus.core_sel), 32'd1);
      check("rst-mid enc_count", 32'(lane[0].bus.enc_count), 32'd0);
      check("rst-mid dec_count", 32'(lane[0].bus.dec_count), 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rst-mid no response", 32'(lane[0].bus.rsp_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end
endmodule
